// File: rtl/readout_pkg.sv
// ============================================================================
// Module  : readout_pkg
// Purpose : Shared types and constants for the readout_scan channel scanner.
//           Holds the scan state encoding, the event-counter width, the
//           hit-word width helper and the default threshold used by benches.
// Config  : READOUT_EVTCNT_EN - when defined, each hit word is widened by an
//           EVTCNT_W-bit event-counter field.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package readout_pkg;

    // Scan state machine encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int EVTCNT_W       = 8;
    localparam int DEFAULT_THRESH = 1000;

    // Width of one stored hit word: {[evtcnt,] channel, sample}
    function automatic int hit_word_w(input int addr_w, input int data_w);
`ifdef READOUT_EVTCNT_EN
        return addr_w + data_w + EVTCNT_W;
`else
        return addr_w + data_w;
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/hit_buffer.sv
// ============================================================================
// Module  : hit_buffer
// Purpose : Simple dual-port hit store. One synchronous write port, one
//           registered read port (read-before-write on a same-index
//           collision). Read data is forced to zero when the read index is at
//           or beyond the current hit count, so the host never sees stale
//           words from an earlier scan.
// Ports   : clk_i    - clock
//           rst_n_i  - async active-low reset (clears the read register only)
//           we_i     - write enable
//           waddr_i  - write index
//           wdata_i  - write word
//           raddr_i  - read index
//           nhit_i   - number of valid entries (masking bound)
//           rdata_o  - registered read word, 1-cycle latency
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hit_buffer #(
    parameter  int DEPTH  = 256,
    parameter  int WORD_W = 24,
    parameter  int NHIT_W = $clog2(DEPTH) + 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    input  logic [NHIT_W-1:0] nhit_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;
    logic              in_range;

    // Zero-extended compare: read index must lie below the hit count
    assign in_range = (NHIT_W'(raddr_i) < nhit_i);

    // Storage is deliberately not reset; validity comes from nhit_i
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Non-blocking read of mem_q gives the pre-write word on a collision
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= in_range ? mem_q[raddr_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/readout_scan.sv
// ============================================================================
// Module  : readout_scan
// Purpose : Scans 2**ADDR_W ADC channels, one per clock, compares each sample
//           against a threshold latched at start, and stores every hit as
//           {channel, sample} in an on-chip buffer. The host reads the hit
//           count, status and buffer over a SEL-gated (tri-stated) bus.
// Ports   : CLK     - clock
//           RST_N   - async active-low reset
//           START   - async start request (synchronised, rising edge acts)
//           THRESH  - threshold, latched on an accepted start
//           ADDR    - channel address to the ADC bus
//           DATA    - ADC sample for ADDR, same cycle
//           SEL     - host select; enables the host-side outputs
//           HADDR   - host buffer read index
//           BUSY    - scan in progress            (Z when SEL=0)
//           DONE    - scan complete, results held (Z when SEL=0)
//           OVF     - buffer overflowed this scan (Z when SEL=0)
//           HNHIT   - number of stored hits       (Z when SEL=0)
//           HDATA   - buffer word at HADDR, 1-cycle latency (Z when SEL=0)
// Config  : READOUT_EVTCNT_EN - adds an 8-bit event counter, bumped on each
//           accepted start; stored words become {evtcnt, channel, sample}.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module readout_scan
    import readout_pkg::*;
#(
    parameter  int ADDR_W = 8,
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 256,
    parameter  int NHIT_W = $clog2(DEPTH) + 1,
    localparam int BUF_AW = $clog2(DEPTH),
    localparam int HDW    = hit_word_w(ADDR_W, DATA_W)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [DATA_W-1:0] THRESH,
    output logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DATA,
    input  logic              SEL,
    input  logic [BUF_AW-1:0] HADDR,
    output logic              BUSY,
    output logic              DONE,
    output logic              OVF,
    output logic [NHIT_W-1:0] HNHIT,
    output logic [HDW-1:0]    HDATA
);

    // ------------------------------------------------------------------
    // START synchroniser and rising-edge detector
    // ------------------------------------------------------------------
    logic start_meta_q;
    logic start_sync_q;
    logic start_prev_q;
    logic start_rise;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            start_meta_q <= 1'b0;
            start_sync_q <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            start_meta_q <= START;
            start_sync_q <= start_meta_q;
            start_prev_q <= start_sync_q;
        end
    end

    assign start_rise = start_sync_q & ~start_prev_q;

    // ------------------------------------------------------------------
    // Scan state machine with registered outputs
    // ------------------------------------------------------------------
    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [NHIT_W-1:0] nhit_q;
    logic [DATA_W-1:0] thresh_q;
    logic              ovf_q;
    logic              done_q;
    logic              busy_q;

    logic              hit;
    logic              buf_full;
    logic              wr_en;
    logic [HDW-1:0]    wr_word;
    logic [HDW-1:0]    rd_word;

    assign hit      = (state_q == ST_SCAN) && (DATA > thresh_q);
    assign buf_full = (nhit_q == NHIT_W'(DEPTH));
    assign wr_en    = hit && !buf_full;

`ifdef READOUT_EVTCNT_EN
    logic [EVTCNT_W-1:0] evtcnt_q;

    // Wraps naturally at 255 -> 0
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            evtcnt_q <= '0;
        end else if (start_rise && (state_q != ST_SCAN)) begin
            evtcnt_q <= evtcnt_q + 1'b1;
        end
    end

    assign wr_word = {evtcnt_q, addr_q, DATA};
`else
    assign wr_word = {addr_q, DATA};
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            nhit_q   <= '0;
            thresh_q <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_rise) begin
                        thresh_q <= THRESH;
                        nhit_q   <= '0;
                        ovf_q    <= 1'b0;
                        done_q   <= 1'b0;
                        addr_q   <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_SCAN;
                    end
                end

                ST_SCAN: begin
                    // Start edges are ignored here; the scan cannot restart
                    if (hit) begin
                        if (buf_full) begin
                            ovf_q <= 1'b1;
                        end else begin
                            nhit_q <= nhit_q + 1'b1;
                        end
                    end
                    if (addr_q == {ADDR_W{1'b1}}) begin
                        addr_q  <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Hit storage
    // ------------------------------------------------------------------
    hit_buffer #(
        .DEPTH  (DEPTH),
        .WORD_W (HDW),
        .NHIT_W (NHIT_W)
    ) u_hit_buffer (
        .clk_i   (CLK),
        .rst_n_i (RST_N),
        .we_i    (wr_en),
        .waddr_i (nhit_q[BUF_AW-1:0]),
        .wdata_i (wr_word),
        .raddr_i (HADDR),
        .nhit_i  (nhit_q),
        .rdata_o (rd_word)
    );

    // ------------------------------------------------------------------
    // Outputs: ADC address always driven, host side gated by SEL
    // ------------------------------------------------------------------
    assign ADDR  = addr_q;
    assign BUSY  = SEL ? busy_q  : 1'bz;
    assign DONE  = SEL ? done_q  : 1'bz;
    assign OVF   = SEL ? ovf_q   : 1'bz;
    assign HNHIT = SEL ? nhit_q  : {NHIT_W{1'bz}};
    assign HDATA = SEL ? rd_word : {HDW{1'bz}};

endmodule

`default_nettype wire

// File: tb/tb_readout_scan.sv
// ============================================================================
// Module  : tb_readout_scan
// Purpose : Self-checking bench for readout_scan. Instance A uses default
//           parameters with a channel-dependent ADC model; instance B uses
//           DEPTH=4 with every channel at 2000 to exercise overflow.
// Config  : READOUT_EVTCNT_EN - expects widened words and checks the counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_readout_scan;
    import readout_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
`ifdef READOUT_EVTCNT_EN
    localparam int HDW = ADDR_W + DATA_W + 8;
`else
    localparam int HDW = ADDR_W + DATA_W;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              start;
    logic              sel;
    logic [DATA_W-1:0] thresh;
    logic [7:0]        haddr_a;
    logic [1:0]        haddr_b;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    int                mode;

    wire               busy_a, done_a, ovf_a;
    wire [8:0]         hnhit_a;
    wire [HDW-1:0]     hdata_a;
    wire               busy_b, done_b, ovf_b;
    wire [2:0]         hnhit_b;
    wire [HDW-1:0]     hdata_b;

    // ADC model: mode 0 hits just above 1000, mode 1 exercises the 1999 bound
    function automatic logic [DATA_W-1:0] adc(input int m, input logic [7:0] ch);
        if (m == 0) begin
            return (ch == 8'd5 || ch == 8'd17 || ch == 8'd255) ? 16'd1001 : 16'd1000;
        end
        case (ch)
            8'd40:   return 16'd2000;
            8'd77:   return 16'd1999;
            8'd200:  return 16'd65535;
            default: return 16'd1000;
        endcase
    endfunction

    assign data_a = adc(mode, addr_a);
    assign data_b = 16'd2000;

    readout_scan u_dut_a (
        .CLK(clk), .RST_N(rst_n), .START(start), .THRESH(thresh),
        .ADDR(addr_a), .DATA(data_a), .SEL(sel), .HADDR(haddr_a),
        .BUSY(busy_a), .DONE(done_a), .OVF(ovf_a), .HNHIT(hnhit_a), .HDATA(hdata_a)
    );

    readout_scan #(.DEPTH(4)) u_dut_b (
        .CLK(clk), .RST_N(rst_n), .START(start), .THRESH(thresh),
        .ADDR(addr_b), .DATA(data_b), .SEL(sel), .HADDR(haddr_b),
        .BUSY(busy_b), .DONE(done_b), .OVF(ovf_b), .HNHIT(hnhit_b), .HDATA(hdata_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_z(input string name, input bit is_z, input logic [63:0] act);
        n_vec++;
        if (!is_z) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected Z", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [HDW-1:0] word(input logic [7:0] ev, input logic [7:0] ch,
                                            input logic [15:0] d);
`ifdef READOUT_EVTCNT_EN
        return {ev, ch, d};
`else
        return {ch, d} | HDW'(ev & 8'h00);
`endif
    endfunction

    // Read-back vectors, applied to both instances in parallel
    typedef struct {
        logic [7:0]     ha;
        logic [HDW-1:0] ea;
        logic [1:0]     hb;
        logic [HDW-1:0] eb;
    } rd_t;

    rd_t rd_tbl[8];

    task automatic apply_reads(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            haddr_a = rd_tbl[i].ha;
            haddr_b = rd_tbl[i].hb;
            tick();
            chk($sformatf("%s_a[%0d]", tag, i), 64'(hdata_a), 64'(rd_tbl[i].ea));
            chk($sformatf("%s_b[%0d]", tag, i), 64'(hdata_b), 64'(rd_tbl[i].eb));
        end
    endtask

    logic [8:0] nhit_entry;
    logic       ovfb_entry;

    // Pulse START, wait for BUSY, count BUSY cycles. A second START pulse is
    // raised at scan cycle glitch_at (negative: none).
    task automatic do_scan(input string tag, input int glitch_at, output int nbusy);
        int guard;
        guard = 0;
        nbusy = 0;
        start = 1'b1;
        while (busy_a !== 1'b1 && guard < 8) begin
            tick();
            guard++;
        end
        chk({tag, "_start_seen"}, 64'(busy_a), 64'd1);
        nhit_entry = hnhit_a;
        ovfb_entry = ovf_b;
        while (busy_a === 1'b1 && nbusy < 400) begin
            if (nbusy == 2) start = 1'b0;
            if (glitch_at >= 0 && nbusy == glitch_at) start = 1'b1;
            if (glitch_at >= 0 && nbusy == glitch_at + 4) start = 1'b0;
            if (glitch_at >= 0 && nbusy == 100) chk({tag, "_addr_mid"}, 64'(addr_a), 64'd100);
            nbusy++;
            tick();
        end
        start = 1'b0;
    endtask

    int nb;
    int guard;

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        sel     = 1'b1;
        thresh  = 16'(DEFAULT_THRESH);
        haddr_a = '0;
        haddr_b = '0;
        mode    = 0;
        tick();
        tick();

        // Reset state
        chk("rst_busy",  64'(busy_a),  64'd0);
        chk("rst_done",  64'(done_a),  64'd0);
        chk("rst_ovf",   64'(ovf_a),   64'd0);
        chk("rst_nhit",  64'(hnhit_a), 64'd0);
        chk("rst_addr",  64'(addr_a),  64'd0);
        chk("rst_hdata", 64'(hdata_a), 64'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // Scan 1, with an ignored START pulse at scan cycle 50
        do_scan("s1", 50, nb);
        chk("s1_busy_len", 64'(nb),      64'd256);
        chk("s1_done",     64'(done_a),  64'd1);
        chk("s1_busy_off", 64'(busy_a),  64'd0);
        chk("s1_nhit",     64'(hnhit_a), 64'd3);
        chk("s1_ovf",      64'(ovf_a),   64'd0);
        chk("s1_addr0",    64'(addr_a),  64'd0);
        chk("s1_nhit_b",   64'(hnhit_b), 64'd4);
        chk("s1_ovf_b",    64'(ovf_b),   64'd1);
        chk("s1_done_b",   64'(done_b),  64'd1);
        // Nothing restarts after DONE from the mid-scan pulse
        for (int i = 0; i < 6; i++) tick();
        chk("s1_no_restart", 64'(busy_a), 64'd0);

        rd_tbl[0] = '{8'd0,   word(8'd1, 8'd5,   16'd1001), 2'd0, word(8'd1, 8'd0, 16'd2000)};
        rd_tbl[1] = '{8'd1,   word(8'd1, 8'd17,  16'd1001), 2'd1, word(8'd1, 8'd1, 16'd2000)};
        rd_tbl[2] = '{8'd2,   word(8'd1, 8'd255, 16'd1001), 2'd2, word(8'd1, 8'd2, 16'd2000)};
        rd_tbl[3] = '{8'd3,   '0,                            2'd3, word(8'd1, 8'd3, 16'd2000)};
        rd_tbl[4] = '{8'd255, '0,                            2'd0, word(8'd1, 8'd0, 16'd2000)};
        apply_reads("s1_rd", 5);

        // Host select gating
        sel = 1'b0;
        #1;
        chk_z("sel0_busy",  busy_a  === 1'bz,          64'(busy_a));
        chk_z("sel0_done",  done_a  === 1'bz,          64'(done_a));
        chk_z("sel0_ovf",   ovf_a   === 1'bz,          64'(ovf_a));
        chk_z("sel0_hnhit", hnhit_a === {9{1'bz}},     64'(hnhit_a));
        chk_z("sel0_hdata", hdata_a === {HDW{1'bz}},   64'(hdata_a));
        sel = 1'b1;
        #1;
        chk("sel1_done", 64'(done_a), 64'd1);

        // One-cycle read latency
        haddr_a = 8'd0;
        tick();
        haddr_a = 8'd1;
        #1;
        chk("lat_old", 64'(hdata_a), 64'(word(8'd1, 8'd5, 16'd1001)));
        tick();
        chk("lat_new", 64'(hdata_a), 64'(word(8'd1, 8'd17, 16'd1001)));

        // Scan 2 from DONE with THRESH=1999
        mode   = 1;
        thresh = 16'd1999;
        do_scan("s2", -1, nb);
        chk("s2_entry_nhit",  64'(nhit_entry), 64'd0);
        chk("s2_entry_ovf_b", 64'(ovfb_entry), 64'd0);
        chk("s2_busy_len",    64'(nb),         64'd256);
        chk("s2_nhit",        64'(hnhit_a),    64'd2);
        chk("s2_ovf",         64'(ovf_a),      64'd0);
        chk("s2_ovf_b",       64'(ovf_b),      64'd1);
        rd_tbl[0] = '{8'd0, word(8'd2, 8'd40,  16'd2000),  2'd0, word(8'd2, 8'd0, 16'd2000)};
        rd_tbl[1] = '{8'd1, word(8'd2, 8'd200, 16'd65535), 2'd3, word(8'd2, 8'd3, 16'd2000)};
        rd_tbl[2] = '{8'd2, '0,                             2'd1, word(8'd2, 8'd1, 16'd2000)};
        apply_reads("s2_rd", 3);

        // Reset at scan cycle 100
        mode   = 0;
        thresh = 16'(DEFAULT_THRESH);
        start  = 1'b1;
        guard  = 0;
        while (busy_a !== 1'b1 && guard < 8) begin
            tick();
            guard++;
        end
        chk("s3_start_seen", 64'(busy_a), 64'd1);
        start = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_busy",  64'(busy_a),  64'd0);
        chk("abort_done",  64'(done_a),  64'd0);
        chk("abort_ovf",   64'(ovf_a),   64'd0);
        chk("abort_nhit",  64'(hnhit_a), 64'd0);
        chk("abort_addr",  64'(addr_a),  64'd0);
        chk("abort_hdata", 64'(hdata_a), 64'd0);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_abort_nhit", 64'(hnhit_a), 64'd0);
        chk("post_abort_done", 64'(done_a),  64'd0);
        chk("post_abort_busy", 64'(busy_a),  64'd0);

        // Three consecutive scans; event counter 1, 2, 3
        haddr_a = 8'd0;
        haddr_b = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            do_scan($sformatf("ev%0d", k), -1, nb);
            chk($sformatf("ev%0d_nhit", k), 64'(hnhit_a), 64'd3);
            rd_tbl[0] = '{8'd0, word(8'(k), 8'd5, 16'd1001), 2'd0, word(8'(k), 8'd0, 16'd2000)};
            apply_reads($sformatf("ev%0d_rd", k), 1);
        end

`ifdef READOUT_EVTCNT_EN
        // 253 more starts: 256 since reset, counter wraps to 0
        for (int k = 4; k <= 256; k++) begin
            do_scan("wrap", -1, nb);
        end
        rd_tbl[0] = '{8'd0, word(8'd0, 8'd5, 16'd1001), 2'd0, word(8'd0, 8'd0, 16'd2000)};
        apply_reads("wrap_rd", 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/readout_scan.md
Name: readout_scan

Overview:
- Parametrised successor of the single-chain readout.
- Scans `2**ADDR_W` ADC channels over the module data bus and compares each sample against a threshold.
- Stores every hit (`{channel, sample}`) in an on-chip buffer.
- Exposes the hit count, status and buffer contents to the host over the shared, SEL-gated host bus.

Parameters:
- `ADDR_W`, 8: channel address width; channels scanned = `2**ADDR_W`.
- `DATA_W`, 16: ADC sample width.
- `DEPTH`, 256: hit buffer entries; power of two, ≥ 2.
- `NHIT_W`, `$clog2(DEPTH)+1`: hit-count width; must hold `DEPTH`.

Ports:
- `CLK` input 1: synchronous clock.
- `RST_N` input 1: asynchronous active-low reset.
- `START` input 1: asynchronous start request; 2-flop synchronised, rising edge acts.
- `THRESH` input `DATA_W`: threshold, latched on the accepted start edge.
- `ADDR` output `ADDR_W`: channel address driven to the ADC data bus.
- `DATA` input `DATA_W`: ADC sample for the current `ADDR`, valid in the same cycle.
- `SEL` input 1: host select; enables host-side outputs.
- `HADDR` input `$clog2(DEPTH)`: host buffer read address.
- `BUSY` output 1: scan in progress; Hi-Z when `SEL=0`.
- `DONE` output 1: scan complete, results stable; Hi-Z when `SEL=0`.
- `OVF` output 1: buffer overflowed this scan; Hi-Z when `SEL=0`.
- `HNHIT` output `NHIT_W`: hits stored; Hi-Z when `SEL=0`.
- `HDATA` output `HDW`: buffer word at `HADDR`; Hi-Z when `SEL=0`. `HDW = ADDR_W+DATA_W` (+8 with the optional feature).

Behaviour:
- Reset (`RST_N=0`, async):
  - state IDLE; `ADDR=0`, NHIT=0, OVF=0, DONE=0, BUSY=0.
  - synchroniser and edge flops cleared; latched threshold = 0.
  - buffer contents are not cleared.
- Start edge: a rising edge of synchronised START is detected 2–3 cycles after the async edge. It is accepted only in IDLE or DONE. It:
  - latches THRESH;
  - clears NHIT, OVF, DONE;
  - sets `ADDR=0`;
  - moves to SCAN.
- Edges during SCAN are ignored; no restart.
- State machine:
  - IDLE: waits for an accepted start.
  - SCAN: one channel per cycle; `BUSY=1`.
  - DONE: `DONE=1`; holds results until the next accepted start.
- SCAN, each cycle:
  - hit iff `DATA > latched threshold` (unsigned, strict).
  - On a hit with `NHIT < DEPTH`: write `{ADDR, DATA}` at index `NHIT[$clog2(DEPTH)-1:0]`, then `NHIT <= NHIT+1`.
  - On a hit with `NHIT == DEPTH`: no write, NHIT saturates, `OVF <= 1` (sticky until the next start).
  - `ADDR` increments every cycle. When `ADDR == 2**ADDR_W-1`, evaluate that channel, then go to DONE with `ADDR` back to 0.
  - Scan length is exactly `2**ADDR_W` cycles.
- BUSY/DONE timing:
  - BUSY rises the cycle SCAN is entered and falls the cycle DONE is entered.
  - NHIT and OVF are final when DONE rises.
- Host read:
  - `HDATA` is registered with 1-cycle latency from HADDR.
  - If `HADDR >= NHIT`, HDATA reads 0.
  - Reads are legal in any state; reads during SCAN return a coherent but possibly in-progress image.
  - A simultaneous write and read of the same index returns the old word (read-before-write).
- Reset mid-scan: aborts immediately to IDLE. A partial buffer is not reported because `NHIT=0`.

Optional Feature:
- `READOUT_EVTCNT_EN`:
  - An 8-bit event counter (reset 0) increments on each accepted start and wraps at 255→0.
  - Each stored word is `{evtcnt, ADDR, DATA}`; HDATA widens by 8.
- Without the macro: no counter; the word is `{ADDR, DATA}`.

Decomposition:
- Package `readout_pkg`:
  - state enum (IDLE, SCAN, DONE);
  - `EVTCNT_W=8`;
  - width helper for the hit word;
  - default threshold constant 1000 for benches.
- Sub-module `hit_buffer`: simple dual-port RAM (1 write port, 1 registered read port, read-before-write). It is parametrised by `DEPTH` and word width, and owns the `HADDR>=NHIT` zero-masking.

Test Plan:
- Defaults, THRESH=1000; DATA=1001 on channels 5, 17, 255, else 1000:
  - after the start edge, BUSY for 256 cycles, then DONE;
  - HNHIT=3, OVF=0;
  - HADDR 0/1/2 → `{5,1001}`, `{17,1001}`, `{255,1001}`; HADDR 3 → 0.
- `DEPTH=4`, all channels DATA=2000:
  - HNHIT=4, OVF=1;
  - buffer holds channels 0–3 only.
- Second START pulse mid-scan (cycle 50) is ignored: DONE still comes 256 cycles after the first. A later START from DONE clears HNHIT/OVF and rescans with the new THRESH=1999, giving hits only where DATA>1999.
- `RST_N` asserted at scan cycle 100:
  - all outputs return to reset values in the same cycle, no clock edge needed;
  - after release, HNHIT=0 and DONE=0.
- `SEL=0`: BUSY/DONE/OVF/HNHIT/HDATA all Z. `SEL=1`: HDATA valid 1 cycle after an HADDR change.
- `READOUT_EVTCNT_EN`: three consecutive scans; hit words carry evtcnt 1, 2, 3. After 256 starts the counter wraps to 0.
